jstk_spi_responder: RTL
=======================

Name: jstk_spi_responder

Overview:
- SPI slave (responder) that emulates the PmodJSTK joystick. It is the far end of the joystick SPI link that the paddle logic polls as master.
- Used as a bench/board stand-in for the joystick: answers each 5-byte poll with the presented X/Y/button values and latches the LED command byte sent by the master.
- All logic runs in the clk50M domain. cs, sck and mosi are oversampled through synchronizers.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on cs, sck and mosi (minimum 2).

Ports:
- clk50M  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- cs  in  1  SPI chip select, active-low, asynchronous to clk50M.
- sck  in  1  SPI clock from the master, mode 0.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- joy_x  in  10  X position to report.
- joy_y  in  10  Y position to report.
- buttons  in  3  button states to report; bit0 = joystick, bit1 = btn1, bit2 = btn2.
- leds  out  2  LED bits from the last valid command byte.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on a completed 40-bit frame.

Behaviour:
- Reset is synchronous and active-high on clk50M. Reset values: miso=0, leds=2'b00, busy=0, frame_done=0, bit counter=0, state=WAIT_IDLE.
- Synchronizers: cs_s, sck_s and mosi_s are SYNC_STAGES flops each. sck edges are detected on the synchronized signal with one extra history flop.
- Minimum sck high and low time is 4 clk50M cycles. Faster sck is unsupported.
- WAIT_IDLE: wait for cs_s=1, then go to IDLE. This stage prevents joining a frame already in progress, for example after a reset mid-frame.
- IDLE, on cs_s falling:
  - Snapshot a 40-bit tx packet, MSB of byte 0 first:
    - byte0 = joy_x[7:0]
    - byte1 = {6'b0, joy_x[9:8]}
    - byte2 = joy_y[7:0]
    - byte3 = {6'b0, joy_y[9:8]}
    - byte4 = {5'b0, buttons}
  - Drive miso = packet bit 39 in the same cycle the fall is detected.
  - Set bit counter = 0, busy = 1, then go to SHIFT.
- SHIFT, on sck_s rising: shift mosi_s into an 8-bit rx register and increment the bit counter (6 bits).
- SHIFT, on sck_s falling: if the counter is below 40, drive the next packet bit on miso; otherwise drive 0.
- Command byte: when the counter reaches 8, inspect rx.
  - If rx[7:2] = 6'b100000, leds <= rx[1:0] in the following cycle.
  - Any other value is ignored and leds are held.
- Bits beyond 40: mosi is ignored and miso stays 0. The counter saturates at 40.
- SHIFT, on cs_s rising:
  - If the counter equals 40: pulse frame_done for exactly 1 cycle.
  - If the counter is not 40: abort, with no frame_done.
  - In both cases: busy=0, miso=0, go to IDLE.
- Simultaneous sck edge and cs rise in the same cycle: the cs rise wins and the sck edge is discarded.
- miso = 0 whenever the state is not SHIFT.
- joy_x, joy_y and buttons may change at any time. Only the value at the frame start is reported.

Optional Feature:
- Macro JSTK_ERR_CNT_EN.
- Defined:
  - Adds output port err_count (out, 8 bits, reset value 0).
  - err_count increments on each aborted frame (cs rise with counter not 40) and each rejected command byte.
  - The counter saturates at 255.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, joy_x=10'h2A5, joy_y=10'h13C, buttons=3'b101; master sends 5 bytes 0x81,0,0,0,0 at sck=1 MHz -> miso bytes A5,02,3C,01,05; leds=2'b01; one frame_done pulse; busy low after cs high.
- Master sends first byte 0x47 -> leds unchanged at 2'b01; data bytes still correct; err_count+1 when JSTK_ERR_CNT_EN is defined.
- cs raised after 20 bits -> no frame_done, busy=0, miso=0. The next full frame returns correct data. err_count+1 when JSTK_ERR_CNT_EN is defined.
- joy_x changed to 10'h3FF mid-frame -> current frame still reports the snapshot value; next frame reports FF,03.
- Assert reset while cs low at bit 12, then release with cs still low and send sck pulses -> miso=0, no frame_done. After cs high then low, a full frame completes normally.
- Master clocks 48 bits -> first 40 bits correct, last 8 bits 0, one frame_done on cs rise.

Source files
------------

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: PmodJSTK-compatible SPI slave answering 5-byte polls; optional JSTK_ERR_CNT_EN adds err_count
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] joy_x,
    input  logic [9:0] joy_y,
    input  logic [2:0] buttons,
    output logic [1:0] leds,
    output logic       busy,
    output logic       frame_done
`ifdef JSTK_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] cs_q, sck_q, mosi_q;
    logic cs_d, sck_d, cs_s, sck_s, mosi_s;
    logic start, fin, abort, shift_rise, shift_fall, chk, rej;
    logic [5:0] cnt;
    logic [7:0] rx;
    logic [38:0] pkt;
    logic [39:0] snap;
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign snap   = {joy_x[7:0], 6'b0, joy_x[9:8], joy_y[7:0], 6'b0, joy_y[9:8], 5'b0, buttons};
    assign rej    = chk && rx[7:2] != 6'b100000;
    // input synchronizers plus edge-history flops; cs resets low so a frame in progress is never joined
    always_ff @(posedge clk50M) begin
        if (reset) begin
            cs_q   <= '0;
            sck_q  <= '0;
            mosi_q <= '0;
            cs_d   <= 1'b0;
            sck_d  <= 1'b0;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            cs_d   <= cs_s;
            sck_d  <= sck_s;
        end
    end
    // state register
    always_ff @(posedge clk50M) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_n;
    end
    // next-state and frame strobes; a cs rise masks any sck edge in the same cycle
    always_comb begin
        state_n    = state;
        start      = 1'b0;
        fin        = 1'b0;
        abort      = 1'b0;
        shift_rise = 1'b0;
        shift_fall = 1'b0;
        case (state)
            WAIT_IDLE: state_n = cs_s ? IDLE : WAIT_IDLE;
            IDLE: begin
                start   = cs_d && !cs_s;
                state_n = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (cs_s && !cs_d) begin
                    state_n = IDLE;
                    fin     = cnt == 6'd40;
                    abort   = cnt != 6'd40;
                end else begin
                    shift_rise = sck_s && !sck_d;
                    shift_fall = !sck_s && sck_d;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end
    // shift datapath, command decode and status outputs
    always_ff @(posedge clk50M) begin
        if (reset) begin
            miso       <= 1'b0;
            leds       <= 2'b00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            rx         <= '0;
            pkt        <= '0;
            chk        <= 1'b0;
        end else begin
            frame_done <= fin;
            chk        <= shift_rise && cnt == 6'd7;
            if (chk && !rej) leds <= rx[1:0];
            if (start) begin
                pkt  <= snap[38:0];
                miso <= snap[39];
                cnt  <= '0;
                busy <= 1'b1;
            end else if (fin || abort) begin
                busy <= 1'b0;
                miso <= 1'b0;
            end else begin
                if (shift_rise && cnt < 6'd40) begin
                    rx  <= {rx[6:0], mosi_s};
                    cnt <= cnt + 6'd1;
                end
                if (shift_fall) begin
                    pkt  <= {pkt[37:0], 1'b0};
                    miso <= cnt < 6'd40 && pkt[38];
                end
            end
        end
    end
`ifdef JSTK_ERR_CNT_EN
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_count} + {8'b0, abort} + {8'b0, rej};
    // saturating count of aborted frames and rejected command bytes
    always_ff @(posedge clk50M) begin
        if (reset) err_count <= '0;
        else       err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif
endmodule
